// File: rtl/com_pkg.sv
// Shared types and constants for the command scheduler.
// Covers command type codes, command field widths and scheduler state encodings.
package com_pkg;

    localparam int unsigned COM_CMD_W  = 12;
    localparam int unsigned TRGG_CMD_W = 40;

    localparam logic [3:0] BTYPE_INIT = 4'd0;
    localparam logic [3:0] BTYPE_CONF = 4'd1;
    localparam logic [3:0] BTYPE_READ = 4'd2;
    localparam logic [3:0] BTYPE_STOP = 4'd3;
    localparam logic [3:0] BTYPE_RXD0 = 4'd4;
    localparam logic [3:0] BTYPE_RXD1 = 4'd5;

    typedef enum logic [5:0] {
        StIdle = 6'b000001,
        StWait = 6'b000010,
        StLoad = 6'b000100,
        StConf = 6'b001000,
        StTxd  = 6'b010000,
        StRest = 6'b100000
    } sched_state_e;

endpackage

// File: rtl/com_sched_wdog.sv
// Watchdog for the scheduler's CONF/TXD waits: counts while active, clears when idle.
// Used only when COM_SCHED_WDOG_EN is defined.
module com_sched_wdog #(
    parameter logic [15:0] WDOG_MAX = 16'hFFFF
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    output logic expire_o
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = active_i ? cnt_q + 16'd1 : 16'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Counter reads 0 in the first active cycle, so this fires after WDOG_MAX active cycles.
    assign expire_o = active_i && (cnt_q == WDOG_MAX - 16'd1);

endmodule

// File: rtl/com_sched.sv
// Command scheduler: accepts decoded commands from the reader and runs config/run/tx actions.
// Optional watchdog on the config/tx waits is enabled by defining COM_SCHED_WDOG_EN.
module com_sched
    import com_pkg::*;
#(
`ifdef COM_SCHED_WDOG_EN
    parameter logic [15:0] WDOG_MAX = 16'hFFFF,
`endif
    parameter int unsigned ERR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fs_read,
    output logic                  fd_read,
    input  logic [3:0]            btype,
    input  logic [COM_CMD_W-1:0]  com_cmd,
    input  logic [TRGG_CMD_W-1:0] trgg_cmd,
    output logic                  fs_conf,
    input  logic                  fd_conf,
    output logic [COM_CMD_W-1:0]  conf_cmd,
    output logic [TRGG_CMD_W-1:0] conf_trgg,
    output logic                  fs_txd,
    input  logic                  fd_txd,
    output logic                  txd_sel,
    output logic                  run,
    output logic [15:0]           cmd_cnt,
    output logic [ERR_W-1:0]      err_cnt,
    output logic                  wdog_err
);

    sched_state_e          state_q, state_d;
    logic [3:0]            btype_q, btype_d;
    logic [COM_CMD_W-1:0]  cmd_q, cmd_d;
    logic [TRGG_CMD_W-1:0] trgg_q, trgg_d;
    logic [COM_CMD_W-1:0]  conf_cmd_q, conf_cmd_d;
    logic [TRGG_CMD_W-1:0] conf_trgg_q, conf_trgg_d;
    logic                  txd_sel_q, txd_sel_d;
    logic                  run_q, run_d;
    logic [15:0]           cmd_cnt_q, cmd_cnt_d;
    logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;
    logic                  wdog_err_q, wdog_err_d;
    logic                  err_inc;
    logic                  wdog_exp;

`ifdef COM_SCHED_WDOG_EN
    logic wdog_active;
    assign wdog_active = (state_q == StConf) || (state_q == StTxd);

    com_sched_wdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .active_i (wdog_active),
        .expire_o (wdog_exp)
    );
`else
    assign wdog_exp = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        btype_d     = btype_q;
        cmd_d       = cmd_q;
        trgg_d      = trgg_q;
        conf_cmd_d  = conf_cmd_q;
        conf_trgg_d = conf_trgg_q;
        txd_sel_d   = txd_sel_q;
        run_d       = run_q;
        cmd_cnt_d   = cmd_cnt_q;
        wdog_err_d  = wdog_err_q;
        err_inc     = 1'b0;

        unique case (state_q)
            StIdle: state_d = StWait;
            StWait: begin
                if (fs_read) begin
                    btype_d   = btype;
                    cmd_d     = com_cmd;
                    trgg_d    = trgg_cmd;
                    cmd_cnt_d = cmd_cnt_q + 16'd1;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                // A still-high fd from the previous transfer stalls dispatch here.
                case (btype_q)
                    BTYPE_CONF: begin
                        if (!fd_conf) begin
                            conf_cmd_d  = cmd_q;
                            conf_trgg_d = trgg_q;
                            run_d       = 1'b0;
                            state_d     = StConf;
                        end
                    end
                    BTYPE_RXD0, BTYPE_RXD1: begin
                        if (!fd_txd) begin
                            txd_sel_d = btype_q[0];
                            state_d   = StTxd;
                        end
                    end
                    BTYPE_READ: begin
                        run_d   = 1'b1;
                        state_d = StRest;
                    end
                    BTYPE_STOP: begin
                        run_d   = 1'b0;
                        state_d = StRest;
                    end
                    BTYPE_INIT: begin
                        err_inc = 1'b1;
                        state_d = StRest;
                    end
                    default: begin
                        err_inc = 1'b1;
                        state_d = StRest;
                    end
                endcase
            end
            StConf: begin
                if (fd_conf) begin
                    state_d = StRest;
                end else if (wdog_exp) begin
                    err_inc    = 1'b1;
                    wdog_err_d = 1'b1;
                    state_d    = StRest;
                end
            end
            StTxd: begin
                if (fd_txd) begin
                    state_d = StRest;
                end else if (wdog_exp) begin
                    err_inc    = 1'b1;
                    wdog_err_d = 1'b1;
                    state_d    = StRest;
                end
            end
            StRest: begin
                if (!fs_read) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        err_cnt_d = (err_inc && !(&err_cnt_q)) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            btype_q     <= 4'd0;
            cmd_q       <= '0;
            trgg_q      <= '0;
            conf_cmd_q  <= '0;
            conf_trgg_q <= '0;
            txd_sel_q   <= 1'b0;
            run_q       <= 1'b0;
            cmd_cnt_q   <= 16'd0;
            err_cnt_q   <= '0;
            wdog_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            btype_q     <= btype_d;
            cmd_q       <= cmd_d;
            trgg_q      <= trgg_d;
            conf_cmd_q  <= conf_cmd_d;
            conf_trgg_q <= conf_trgg_d;
            txd_sel_q   <= txd_sel_d;
            run_q       <= run_d;
            cmd_cnt_q   <= cmd_cnt_d;
            err_cnt_q   <= err_cnt_d;
            wdog_err_q  <= wdog_err_d;
        end
    end

    assign fd_read   = (state_q == StRest);
    assign fs_conf   = (state_q == StConf);
    assign fs_txd    = (state_q == StTxd);
    assign conf_cmd  = conf_cmd_q;
    assign conf_trgg = conf_trgg_q;
    assign txd_sel   = txd_sel_q;
    assign run       = run_q;
    assign cmd_cnt   = cmd_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign wdog_err  = wdog_err_q;

endmodule

// File: tb/tb_com_sched.sv
// Directed bench for com_sched: run control, config, transmit, errors, watchdog and reset.
// The watchdog section is selected by COM_SCHED_WDOG_EN, matching the RTL build.
module tb_com_sched;

    logic        clk;
    logic        rst;
    logic        fs_read;
    logic        fd_read;
    logic [3:0]  btype;
    logic [11:0] com_cmd;
    logic [39:0] trgg_cmd;
    logic        fs_conf;
    logic        fd_conf;
    logic [11:0] conf_cmd;
    logic [39:0] conf_trgg;
    logic        fs_txd;
    logic        fd_txd;
    logic        txd_sel;
    logic        run;
    logic [15:0] cmd_cnt;
    logic [7:0]  err_cnt;
    logic        wdog_err;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;
    int exp_err  = 0;

    com_sched #(
`ifdef COM_SCHED_WDOG_EN
        .WDOG_MAX (16'd16),
`endif
        .ERR_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .fs_read   (fs_read),
        .fd_read   (fd_read),
        .btype     (btype),
        .com_cmd   (com_cmd),
        .trgg_cmd  (trgg_cmd),
        .fs_conf   (fs_conf),
        .fd_conf   (fd_conf),
        .conf_cmd  (conf_cmd),
        .conf_trgg (conf_trgg),
        .fs_txd    (fs_txd),
        .fd_txd    (fd_txd),
        .txd_sel   (txd_sel),
        .run       (run),
        .cmd_cnt   (cmd_cnt),
        .err_cnt   (err_cnt),
        .wdog_err  (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command while the DUT is in WAIT; returns with the DUT in LOAD.
    task automatic issue(input logic [3:0] b, input logic [11:0] c, input logic [39:0] t);
        btype    = b;
        com_cmd  = c;
        trgg_cmd = t;
        fs_read  = 1'b1;
        tick();
        exp_cnt++;
        chk("load_cmd_cnt", cmd_cnt, 64'(exp_cnt));
        chk("load_fd_read", fd_read, 0);
    endtask

    // Release the reader from REST; returns with the DUT back in WAIT.
    task automatic finish_cmd();
        fs_read = 1'b0;
        tick();
        chk("idle_fd_read", fd_read, 0);
        tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_fd_read"}, fd_read, 0);
        chk({tag, "_fs_conf"}, fs_conf, 0);
        chk({tag, "_fs_txd"}, fs_txd, 0);
        chk({tag, "_run"}, run, 0);
        chk({tag, "_cmd_cnt"}, cmd_cnt, 0);
        chk({tag, "_err_cnt"}, err_cnt, 0);
        chk({tag, "_conf_cmd"}, conf_cmd, 0);
        chk({tag, "_conf_trgg"}, conf_trgg, 0);
        chk({tag, "_txd_sel"}, txd_sel, 0);
        chk({tag, "_wdog_err"}, wdog_err, 0);
    endtask

    initial begin
        rst = 1'b1; fs_read = 1'b0; btype = 4'd0; com_cmd = '0; trgg_cmd = '0;
        fd_conf = 1'b0; fd_txd = 1'b0;
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // READ then STOP then READ
        issue(4'd2, 12'h000, 40'h0);
        chk("read_run_load", run, 0);
        tick();
        chk("read_fd_read", fd_read, 1);
        chk("read_run", run, 1);
        finish_cmd();
        issue(4'd3, 12'h000, 40'h0);
        tick();
        chk("stop_fd_read", fd_read, 1);
        chk("stop_run", run, 0);
        finish_cmd();
        issue(4'd2, 12'h000, 40'h0);
        tick();
        chk("read2_run", run, 1);
        finish_cmd();

        // CONF clears run, holds fs_conf until fd_conf
        issue(4'd1, 12'hA5C, 40'h12_3456_789A);
        chk("conf_run_load", run, 1);
        tick();
        chk("conf_run", run, 0);
        chk("conf_fs_conf", fs_conf, 1);
        chk("conf_cmd", conf_cmd, 64'h0A5C);
        chk("conf_trgg", conf_trgg, 64'h12_3456_789A);
        chk("conf_fd_read", fd_read, 0);
        repeat (9) tick();
        chk("conf_hold", fs_conf, 1);
        fd_conf = 1'b1;
        tick();
        chk("conf_done_fs", fs_conf, 0);
        chk("conf_done_fd_read", fd_read, 1);
        finish_cmd();

        // Stale fd_conf: LOAD stalls without re-latching
        issue(4'd1, 12'h123, 40'hAB_CDEF_0123);
        com_cmd = 12'hFFF;
        tick();
        chk("stale_fs_conf", fs_conf, 0);
        chk("stale_cmd_cnt", cmd_cnt, 64'(exp_cnt));
        fd_conf = 1'b0;
        tick();
        chk("stale_fs_conf_go", fs_conf, 1);
        chk("stale_conf_cmd", conf_cmd, 64'h123);
        chk("stale_conf_trgg", conf_trgg, 64'hAB_CDEF_0123);
        fd_conf = 1'b1;
        tick();
        fd_conf = 1'b0;
        finish_cmd();

        // Transmit selection; run unaffected
        issue(4'd2, 12'h000, 40'h0);
        tick();
        finish_cmd();
        issue(4'd5, 12'h000, 40'h0);
        tick();
        chk("rxd1_fs_txd", fs_txd, 1);
        chk("rxd1_txd_sel", txd_sel, 1);
        chk("rxd1_run", run, 1);
        fd_txd = 1'b1;
        tick();
        chk("rxd1_fs_txd_drop", fs_txd, 0);
        chk("rxd1_fd_read", fd_read, 1);
        fd_txd = 1'b0;
        finish_cmd();
        issue(4'd4, 12'h000, 40'h0);
        tick();
        chk("rxd0_fs_txd", fs_txd, 1);
        chk("rxd0_txd_sel", txd_sel, 0);
        chk("rxd0_run", run, 1);
        fd_txd = 1'b1;
        tick();
        fd_txd = 1'b0;
        finish_cmd();

`ifdef COM_SCHED_WDOG_EN
        // Watchdog abort after 16 cycles in CONF
        issue(4'd1, 12'h00F, 40'h0);
        tick();
        chk("wdog_fs_conf", fs_conf, 1);
        repeat (15) tick();
        chk("wdog_fs_conf_15", fs_conf, 1);
        chk("wdog_err_pre", wdog_err, 0);
        tick();
        exp_err++;
        chk("wdog_fs_conf_drop", fs_conf, 0);
        chk("wdog_fd_read", fd_read, 1);
        chk("wdog_err", wdog_err, 1);
        chk("wdog_err_cnt", err_cnt, 64'(exp_err));
        finish_cmd();
`else
        // Without watchdog, CONF waits indefinitely
        issue(4'd1, 12'h00F, 40'h0);
        tick();
        repeat (40) tick();
        chk("nowdog_fs_conf", fs_conf, 1);
        chk("nowdog_err", wdog_err, 0);
        chk("nowdog_err_cnt", err_cnt, 0);
        fd_conf = 1'b1;
        tick();
        chk("nowdog_fd_read", fd_read, 1);
        fd_conf = 1'b0;
        finish_cmd();
`endif
        // READ again so run should survive bad commands
        issue(4'd2, 12'h000, 40'h0);
        tick();
        finish_cmd();

        // Unknown type counts an error, no downstream request
        issue(4'd9, 12'h000, 40'h0);
        tick();
        exp_err++;
        chk("bad_fd_read", fd_read, 1);
        chk("bad_fs_conf", fs_conf, 0);
        chk("bad_fs_txd", fs_txd, 0);
        chk("bad_err_cnt", err_cnt, 64'(exp_err));
        finish_cmd();
        for (int i = 0; i < 300; i++) begin
            issue((i % 2 == 0) ? 4'd0 : 4'(10 + (i % 6)), 12'h000, 40'h0);
            tick();
            finish_cmd();
        end
        chk("sat_err_cnt", err_cnt, 64'hFF);
        chk("sat_cmd_cnt", cmd_cnt, 64'(exp_cnt));
        chk("sat_run", run, 1);

        // fs_read dropped during LOAD: STOP still completes
        btype   = 4'd3;
        fs_read = 1'b1;
        tick();
        exp_cnt++;
        fs_read = 1'b0;
        tick();
        chk("pulse_run", run, 0);
        chk("pulse_fd_read", fd_read, 1);
        chk("pulse_cmd_cnt", cmd_cnt, 64'(exp_cnt));
        tick();
        chk("pulse_idle", fd_read, 0);
        tick();

        // Asynchronous reset mid-CONF
        issue(4'd1, 12'h777, 40'h55);
        tick();
        chk("rstmid_fs_conf", fs_conf, 1);
        #2;
        rst = 1'b1;
        #1;
        check_zero("rstmid");
        @(posedge clk); #3;
        rst = 1'b0;
        exp_cnt = 0;
        tick();
        issue(4'd2, 12'h000, 40'h0);
        tick();
        chk("after_rst_run", run, 1);
        chk("after_rst_fd_read", fd_read, 1);
        chk("after_rst_cmd_cnt", cmd_cnt, 1);
        finish_cmd();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
